usbfs_tx_phy: RTL and testbench
===============================

// Module: usbfs_tx_phy
// PURPOSE
//   USB full-speed (12Mb/s) transmit line encoder for the USBFS device stack.
//   Takes packet bytes over a valid/ready handshake and drives d+/d-/output-enable.
//   Emits SYNC, LSB-first NRZI data with bit stuffing, then EOP (SE0,SE0,J).
//   Sits between the packet/endpoint logic and the pad IOBUFs. The RX side is
//   fed J while o_oe is high.
// PARAMETERS
//   CLKS_PER_BIT  4  clk_48MHz cycles per USB bit (48/12); must be >= 2
//   STUFF_RUN     6  consecutive 1s that force an inserted 0 bit
// PORTS
//   clk_48MHz   in   1  clock
//   rst         in   1  reset, synchronous, active-high
//   i_cg        in   1  clock-gate enable; 0 freezes all state, outputs hold
//   i_valid     in   1  i_data valid
//   i_data      in   8  packet byte, sent LSB first
//   i_last      in   1  qualifies i_data as final byte of packet
//   o_ready     out  1  byte accepted this cycle when i_valid & o_ready
//   o_dp        out  1  USB d+ drive value
//   o_dn        out  1  USB d- drive value
//   o_oe        out  1  pad output enable (1=drive)
//   o_busy      out  1  packet in progress (state != IDLE)
//   o_underrun  out  1  one-cycle pulse: holding reg empty at data-bit boundary
// BEHAVIOUR
//   Reset: state=IDLE, o_oe=0, o_dp=1, o_dn=0 (J), o_ready=0 during rst,
//     o_busy=0, o_underrun=0, divider=0, ones count=0, holding reg empty.
//   Line: J={dp,dn}=10, K=01, SE0=00. NRZI: bit 0 toggles J<->K, bit 1 holds.
//   Bit timing: divider counts 0..CLKS_PER_BIT-1 while not IDLE. Bit boundary
//     when divider==CLKS_PER_BIT-1. Line outputs change only on the cycle after
//     a boundary, so every bit lasts exactly CLKS_PER_BIT cycles.
//   Holding reg: 1 byte + last flag.
//     o_ready = !rst & !holdFull & !lastAccepted & state in {IDLE,SYNC,DATA}.
//     Combinational; i_valid may depend on it.
//     Shifter loads from holding reg on the boundary after its 8th bit. The
//     holding reg is freed the same cycle, so o_ready can rise the next cycle.
//   States:
//     IDLE -> SYNC on accepted byte at cycle t. o_oe=1 and first K at t+1.
//     SYNC: 8 bits 0x80 LSB first (KJKJKJKK). Ones count=1 after SYNC.
//       At the end of the 8th bit -> DATA, with shifter loaded from holding reg.
//     DATA: each boundary sends the next bit. Ones count increments on 1 and
//       clears on 0.
//       Count reaching STUFF_RUN inserts a 0 (toggle) bit next. The count
//       clears and the shifter does not advance.
//       After 8 bits: if byte was last -> EOP_SE0, but any pending stuff bit
//       is sent first. Else if holding reg full -> load and continue.
//       Else pulse o_underrun and -> EOP_SE0 (packet truncated).
//     EOP_SE0: 2 bits SE0 -> EOP_J. EOP_J: 1 bit J -> IDLE.
//       o_oe=0 the cycle after EOP_J ends. lastAccepted clears in IDLE.
//   Accepted-byte ordering preserved. A byte accepted with i_last ends the
//     packet; no further bytes accepted until IDLE.
//   Packet with N bytes and S stuff bits: o_oe high (8+8N+S+3)*CLKS_PER_BIT.
//   Back-to-back packets: >=1 IDLE cycle with o_oe=0 between EOP_J and SYNC.
//   rst mid-packet: next cycle in reset state (J, o_oe=0). No EOP is emitted.
//   i_cg=0: divider, state and shifter hold. Handshake also holds (o_ready=0).
// TESTING
//   1 byte 0x00,last -> K J K J K J K K | J K J K J K J K | SE0 SE0 J;
//     4 clk/bit; o_oe high 76 cycles.
//   1 byte 0xFF,last -> after SYNC: K K K K K, stuff J, J J J, SE0 SE0 J;
//     o_oe high 80 cycles.
//   3 bytes 0x2D,0x00,0x10(last) with i_valid always high -> o_ready 1 per byte.
//     No underrun. 3*8 data bits follow SYNC. o_busy falls after EOP.
//   2 bytes, 2nd i_valid withheld past 1st byte end -> o_underrun 1 cycle.
//     SE0 SE0 J follows the 1st byte.
//   rst asserted at data bit 5 -> next cycle o_oe=0, dp=1, dn=0, o_ready=0.
//     New packet after rst starts with full SYNC.
//   i_cg=0 for 10 cycles mid-DATA -> line value frozen. Bit resumes and
//     completes with total width CLKS_PER_BIT active cycles.

Source files
------------

// File: rtl/usbfs_tx_phy.sv
// USB full-speed transmit line encoder: SYNC, LSB-first NRZI data with bit stuffing, then EOP.
// Bytes arrive over valid/ready into a one-byte holding register that feeds the bit shifter.
module usbfs_tx_phy #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STUFF_RUN    = 6
) (
    input  logic       clk_48MHz,
    input  logic       rst,
    input  logic       i_cg,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_dp,
    output logic       o_dn,
    output logic       o_oe,
    output logic       o_busy,
    output logic       o_underrun
);

    localparam int unsigned DivW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned OnesW = $clog2(STUFF_RUN + 1);

    localparam logic [DivW-1:0]  DivMax  = DivW'(CLKS_PER_BIT - 1);
    localparam logic [OnesW-1:0] OnesMax = OnesW'(STUFF_RUN);

    localparam logic [1:0] LineJ   = 2'b10;
    localparam logic [1:0] LineK   = 2'b01;
    localparam logic [1:0] LineSe0 = 2'b00;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEopSe0,
        StEopJ
    } state_e;

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [OnesW-1:0] ones_q, ones_d;
    logic [7:0]       hold_data_q, hold_data_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d;
    logic             cur_last_q, cur_last_d;
    logic             last_acc_q, last_acc_d;
    logic [1:0]       line_q, line_d;
    logic             oe_q, oe_d;

    logic boundary;
    logic accept;
    logic load;
    logic send_en;
    logic send_bit;
    logic underrun;

    assign o_ready = !rst && i_cg && !hold_full_q && !last_acc_q &&
                     (state_q == StIdle || state_q == StSync || state_q == StData);
    assign accept  = i_valid && o_ready;

    assign boundary = (state_q != StIdle) && (div_q == DivMax);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        ones_d      = ones_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        hold_full_d = hold_full_q;
        cur_last_d  = cur_last_q;
        last_acc_d  = last_acc_q;
        line_d      = line_q;
        oe_d        = oe_q;
        load        = 1'b0;
        send_en     = 1'b0;
        send_bit    = 1'b0;
        underrun    = 1'b0;

        if (state_q != StIdle) begin
            div_d = boundary ? '0 : div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                // A byte left in the holding register by a truncated packet starts a new one.
                if (accept || hold_full_q) begin
                    state_d = StSync;
                    div_d   = '0;
                    cnt_d   = 4'd1;
                    ones_d  = '0;
                    line_d  = LineK;
                    oe_d    = 1'b1;
                end
            end
            StSync: begin
                if (boundary) begin
                    if (cnt_q != 4'd8) begin
                        send_en  = 1'b1;
                        send_bit = (cnt_q == 4'd7);
                        cnt_d    = cnt_q + 4'd1;
                    end else begin
                        state_d = StData;
                        load    = 1'b1;
                    end
                end
            end
            StData: begin
                if (boundary) begin
                    // A pending stuff bit always goes out before EOP or the next byte.
                    if (ones_q == OnesMax) begin
                        line_d = ~line_q;
                        ones_d = '0;
                    end else if (cnt_q != 4'd8) begin
                        send_en  = 1'b1;
                        send_bit = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        cnt_d    = cnt_q + 4'd1;
                    end else if (cur_last_q) begin
                        state_d = StEopSe0;
                        cnt_d   = 4'd0;
                        line_d  = LineSe0;
                    end else if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        underrun = 1'b1;
                        state_d  = StEopSe0;
                        cnt_d    = 4'd0;
                        line_d   = LineSe0;
                    end
                end
            end
            StEopSe0: begin
                if (boundary) begin
                    if (cnt_q == 4'd1) begin
                        state_d = StEopJ;
                        line_d  = LineJ;
                    end else begin
                        cnt_d = 4'd1;
                    end
                end
            end
            StEopJ: begin
                if (boundary) begin
                    state_d = StIdle;
                    oe_d    = 1'b0;
                    ones_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                oe_d    = 1'b0;
                line_d  = LineJ;
            end
        endcase

        if (load) begin
            send_en     = 1'b1;
            send_bit    = hold_data_q[0];
            shift_d     = {1'b0, hold_data_q[7:1]};
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            cnt_d       = 4'd1;
        end

        // NRZI: a 0 toggles J/K, a 1 holds the line.
        if (send_en) begin
            line_d = send_bit ? line_q : ~line_q;
            ones_d = send_bit ? ones_q + 1'b1 : '0;
        end

        if (accept) begin
            hold_data_d = i_data;
            hold_last_d = i_last;
            hold_full_d = 1'b1;
            last_acc_d  = i_last;
        end else if (state_q == StIdle && !hold_full_q) begin
            last_acc_d = 1'b0;
        end
    end

    always_ff @(posedge clk_48MHz) begin
        if (rst) begin
            state_q     <= StIdle;
            div_q       <= '0;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            ones_q      <= '0;
            hold_data_q <= 8'h00;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            cur_last_q  <= 1'b0;
            last_acc_q  <= 1'b0;
            line_q      <= LineJ;
            oe_q        <= 1'b0;
        end else if (i_cg) begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ones_q      <= ones_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            cur_last_q  <= cur_last_d;
            last_acc_q  <= last_acc_d;
            line_q      <= line_d;
            oe_q        <= oe_d;
        end
    end

    assign o_dp       = line_q[1];
    assign o_dn       = line_q[0];
    assign o_oe       = oe_q;
    assign o_busy     = (state_q != StIdle);
    assign o_underrun = underrun && i_cg;

endmodule

// File: tb/tb_usbfs_tx_phy.sv
// Self-checking bench for usbfs_tx_phy: randomized packets compared against a bit-stream
// model of SYNC + stuffed NRZI data + EOP, plus directed reset, underrun and clock-gate cases.
module tb_usbfs_tx_phy;

    localparam int Cpb      = 4;
    localparam int StuffRun = 6;

    localparam logic [1:0] SymJ   = 2'b10;
    localparam logic [1:0] SymK   = 2'b01;
    localparam logic [1:0] SymSe0 = 2'b00;

    logic       clk_48MHz = 1'b0;
    logic       rst       = 1'b1;
    logic       i_cg      = 1'b1;
    logic       i_valid   = 1'b0;
    logic [7:0] i_data    = 8'h00;
    logic       i_last    = 1'b0;
    logic       o_ready;
    logic       o_dp;
    logic       o_dn;
    logic       o_oe;
    logic       o_busy;
    logic       o_underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] pkt[$];
    logic [1:0] exp_sym[$];
    logic [1:0] cap[$];

    usbfs_tx_phy #(
        .CLKS_PER_BIT(Cpb),
        .STUFF_RUN   (StuffRun)
    ) dut (
        .clk_48MHz (clk_48MHz),
        .rst       (rst),
        .i_cg      (i_cg),
        .i_valid   (i_valid),
        .i_data    (i_data),
        .i_last    (i_last),
        .o_ready   (o_ready),
        .o_dp      (o_dp),
        .o_dn      (o_dn),
        .o_oe      (o_oe),
        .o_busy    (o_busy),
        .o_underrun(o_underrun)
    );

    always #10 clk_48MHz = ~clk_48MHz;

    always @(posedge clk_48MHz) cyc <= cyc + 1;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line symbols per bit for the first n_bytes of pkt, from the USB encoding rules.
    task automatic build_expected(input int n_bytes);
        bit         bits[$];
        int         ones;
        logic [1:0] lvl;
        exp_sym.delete();
        for (int i = 0; i < 8; i++) bits.push_back(i == 7);
        for (int k = 0; k < n_bytes; k++) begin
            for (int b = 0; b < 8; b++) bits.push_back(pkt[k][b]);
        end
        lvl  = SymJ;
        ones = 0;
        foreach (bits[i]) begin
            if (!bits[i]) lvl = (lvl == SymJ) ? SymK : SymJ;
            exp_sym.push_back(lvl);
            ones = bits[i] ? ones + 1 : 0;
            if (ones == StuffRun) begin
                lvl = (lvl == SymJ) ? SymK : SymJ;
                exp_sym.push_back(lvl);
                ones = 0;
            end
        end
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymJ);
    endtask

    task automatic run_packet(input string tag, input bit truncate, input int stall_at,
                              output int oe_len);
        int n_send;
        int acc;
        int acc_cyc;
        int rise_cyc;
        int und;
        int mism;
        int stall_changes;
        bit busy_after;
        n_send        = truncate ? 1 : pkt.size();
        acc           = 0;
        acc_cyc       = -10;
        rise_cyc      = 0;
        und           = 0;
        stall_changes = 0;
        busy_after    = 1'b1;
        cap.delete();
        fork
            begin
                for (int i = 0; i < n_send; i++) begin
                    int t;
                    @(negedge clk_48MHz);
                    i_valid = 1'b1;
                    i_data  = pkt[i];
                    i_last  = !truncate && (i == pkt.size() - 1);
                    #1;
                    t = 0;
                    while (!o_ready && t < 2000) begin
                        @(negedge clk_48MHz);
                        #1;
                        t++;
                    end
                    if (o_ready) begin
                        if (acc == 0) acc_cyc = cyc;
                        acc++;
                    end
                end
                @(negedge clk_48MHz);
                i_valid = 1'b0;
                i_last  = 1'b0;
            end
            begin
                int t;
                t = 0;
                @(negedge clk_48MHz);
                while (!o_oe && t < 3000) begin
                    @(negedge clk_48MHz);
                    t++;
                end
                if (o_oe) begin
                    rise_cyc = cyc;
                    t = 0;
                    while (o_oe && t < 3000) begin
                        if (i_cg) cap.push_back({o_dp, o_dn});
                        if (o_underrun) und++;
                        @(negedge clk_48MHz);
                        t++;
                    end
                    busy_after = o_busy;
                end
            end
            begin
                if (stall_at > 0) begin
                    int t;
                    logic [1:0] held;
                    t = 0;
                    @(negedge clk_48MHz);
                    while (!o_oe && t < 3000) begin
                        @(negedge clk_48MHz);
                        t++;
                    end
                    repeat (stall_at) @(posedge clk_48MHz);
                    #2 i_cg = 1'b0;
                    @(negedge clk_48MHz);
                    held = {o_dp, o_dn};
                    for (int k = 1; k < 10; k++) begin
                        @(negedge clk_48MHz);
                        if ({o_dp, o_dn} != held) stall_changes++;
                    end
                    @(posedge clk_48MHz);
                    #2 i_cg = 1'b1;
                    check_eq({tag, "_frozen"}, stall_changes, 0);
                end
            end
        join

        build_expected(n_send);
        mism = 0;
        for (int i = 0; i < cap.size(); i++) begin
            if (i / Cpb < exp_sym.size()) begin
                if (cap[i] !== exp_sym[i / Cpb]) mism++;
            end else begin
                mism++;
            end
        end
        oe_len = cap.size();
        check_eq({tag, "_accepted"}, acc, n_send);
        check_eq({tag, "_first_k_cycle"}, rise_cyc, acc_cyc + 1);
        check_eq({tag, "_oe_len"}, cap.size(), exp_sym.size() * Cpb);
        check_eq({tag, "_line_errs"}, mism, 0);
        check_eq({tag, "_underruns"}, und, truncate ? 1 : 0);
        check_eq({tag, "_busy_after"}, busy_after, 1'b0);
    endtask

    initial begin
        int len;
        int t;

        repeat (3) @(negedge clk_48MHz);
        check_eq("rst_oe", o_oe, 1'b0);
        check_eq("rst_line", {o_dp, o_dn}, SymJ);
        check_eq("rst_ready", o_ready, 1'b0);
        check_eq("rst_busy", o_busy, 1'b0);
        check_eq("rst_underrun", o_underrun, 1'b0);
        rst = 1'b0;
        #1 check_eq("idle_ready", o_ready, 1'b1);

        pkt.delete();
        pkt.push_back(8'h00);
        run_packet("b00", 1'b0, 0, len);
        check_eq("b00_len76", len, 76);

        pkt.delete();
        pkt.push_back(8'hFF);
        run_packet("bff", 1'b0, 0, len);
        check_eq("bff_len80", len, 80);

        pkt.delete();
        pkt.push_back(8'h2D);
        pkt.push_back(8'h00);
        pkt.push_back(8'h10);
        run_packet("three", 1'b0, 0, len);

        pkt.delete();
        pkt.push_back(8'h3C);
        pkt.push_back(8'h55);
        run_packet("underrun", 1'b1, 0, len);

        // Reset in the second cycle of data bit 5.
        @(negedge clk_48MHz);
        i_valid = 1'b1;
        i_data  = 8'h00;
        i_last  = 1'b1;
        #1;
        t = 0;
        while (!o_ready && t < 100) begin
            @(negedge clk_48MHz);
            #1;
            t++;
        end
        @(negedge clk_48MHz);
        i_valid = 1'b0;
        i_last  = 1'b0;
        check_eq("midrst_oe_up", o_oe, 1'b1);
        repeat ((8 + 5) * Cpb + 1) @(negedge clk_48MHz);
        rst = 1'b1;
        #1 check_eq("midrst_ready_in_rst", o_ready, 1'b0);
        @(negedge clk_48MHz);
        check_eq("midrst_oe", o_oe, 1'b0);
        check_eq("midrst_line", {o_dp, o_dn}, SymJ);
        check_eq("midrst_busy", o_busy, 1'b0);
        check_eq("midrst_ready", o_ready, 1'b0);
        rst = 1'b0;
        #1 check_eq("midrst_ready_after", o_ready, 1'b1);

        pkt.delete();
        pkt.push_back(8'h00);
        run_packet("post_rst", 1'b0, 0, len);

        pkt.delete();
        pkt.push_back(8'h00);
        pkt.push_back(8'h81);
        run_packet("cg_stall", 1'b0, (8 + 2) * Cpb + 1, len);

        for (int p = 0; p < 14; p++) begin
            int n;
            n = $urandom_range(1, 4);
            pkt.delete();
            for (int k = 0; k < n; k++) begin
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk_48MHz);
            run_packet($sformatf("rnd%0d", p), 1'b0, 0, len);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
